bin_cnt_down_timer: RTL and testbench
=====================================

# bin_cnt_down_timer

Programmable down-counting period timer, the counterpart of the free-running modulo-N up counter. It counts a latched period down to zero and flags expiry with a one-cycle `tick`. It supports one-shot or auto-reload operation, plus pause/resume and abort. It sits beside the up counter in the binary-counter group and supplies periodic or single timeout events to control logic.

## Interface
- `WIDTH`, default 8: counter and period width in bits.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `load_val`  input  WIDTH  period in clock cycles; 0 encodes 2^WIDTH. Sampled only when a start is accepted from IDLE.
- `mode`  input  1  0 = one-shot, 1 = auto-reload. Sampled together with `load_val`.
- `start`  input  1  level-sampled command: begins a run from IDLE, or resumes from PAUSE.
- `pause`  input  1  RUN → PAUSE; the count holds.
- `abort`  input  1  any state → IDLE; `q` is cleared.
- `q`  output  WIDTH  current remaining count (registered).
- `tick`  output  1  expiry strobe, high for exactly one cycle per expiry.
- `busy`  output  1  high in RUN or PAUSE.
- `paused`  output  1  high in PAUSE.

## Operation
- Internal registers:
  - state: IDLE, RUN or PAUSE.
  - `q`.
  - `period_reg` (WIDTH bits).
  - `mode_reg`.
- Reset (`reset` = 0), effective immediately and asynchronously: state = IDLE, `q` = 0, `period_reg` = 0, `mode_reg` = 0. As a result, `tick` = 0, `busy` = 0 and `paused` = 0.
- Command priority, evaluated each edge: `abort` > `pause` > `start`.
- IDLE:
  - `start` = 1 → RUN.
  - On that transition: `period_reg` ← `load_val`, `mode_reg` ← `mode`, `q` ← `load_val` − 1 (modulo 2^WIDTH, so `load_val` = 0 loads all-ones).
  - `pause` in IDLE is ignored.
- RUN with `q` ≠ 0:
  - `q` ← `q` − 1 each cycle.
  - `pause` → PAUSE with `q` unchanged.
  - `start` is ignored; a run cannot be restarted without `abort`.
- RUN with `q` = 0 (expiry cycle), `tick` = 1:
  - `mode_reg` = 1: `q` ← `period_reg` − 1. Next state is PAUSE if `pause` = 1, otherwise RUN.
  - `mode_reg` = 0: next state is IDLE and `q` stays 0, even if `pause` = 1 (completion wins).
- PAUSE:
  - `q` and `tick` are frozen (`tick` = 0).
  - `start` → RUN with no reload; counting resumes from the held `q`.
- `abort` = 1 in any state → IDLE, `q` ← 0.
  - If `abort` arrives in an expiry cycle, that cycle's `tick` is still output.
- Output decodes (combinational from registers only, Moore):
  - `tick` = (state == RUN) && (`q` == 0).
  - `busy` = (state ≠ IDLE).
  - `paused` = (state == PAUSE).
- Arithmetic:
  - Decrement and reload are WIDTH-bit modulo; no carry out.
  - `q` never underflows in RUN, because `q` = 0 always takes the reload or IDLE path.

## Timing
- Start accepted at edge k → `busy` = 1 and `q` = L − 1 after edge k, where L = `load_val` (L = 0 counts as 2^WIDTH).
- First `tick` is high in the cycle between edges k+L−1 and k+L, i.e. L cycles after start.
- Auto-reload: subsequent ticks occur every L cycles, with no gap cycle.
- One-shot: `busy` falls at edge k+L.
- L = 1 with auto-reload → `tick` is continuously high, one strobe per cycle.
- Pause held for P cycles delays all later ticks by exactly P cycles plus the resume cycle count. Resume takes effect at the edge where `start` is sampled in PAUSE.
- Inputs need to be valid only at the rising edge; no handshake acknowledge. Commands issued in an ignoring state are dropped, not queued.

## Test plan
- One-shot, `load_val` = 5:
  - start at edge 0 → `q` = 4, 3, 2, 1, 0 after edges 0–4.
  - `tick` = 1 only in the cycle after edge 4.
  - `busy` = 0 and `q` = 0 after edge 5.
- Auto-reload, `load_val` = 3, run 12 cycles → exactly 4 ticks, spaced 3 cycles apart; `q` sequence 2, 1, 0, 2, 1, 0, …
- Boundaries:
  - `load_val` = 0 with WIDTH = 8 auto-reload → first tick 256 cycles after start; `q` starts at 255.
  - `load_val` = 1 → `tick` held high every cycle.
- Pause/resume, `load_val` = 6:
  - pause at `q` = 3 → `q` holds 3 for 10 cycles with `tick` = 0 and `paused` = 1.
  - start → `q` = 2, 1, 0 follows and tick fires.
  - pause during the auto-reload expiry cycle → tick seen, then PAUSE with `q` = 5.
- Abort and priority:
  - abort at `q` = 2 → IDLE with `q` = 0 and `busy` = 0 next cycle.
  - abort + pause + start asserted together in RUN → IDLE.
  - start while RUN → no reload.
- Reset mid-run: drive `reset` low between edges during RUN → `q`, `busy`, `tick` and `paused` go to 0 immediately, without waiting for a clock edge. After release, no activity until start.

Source files
------------

// File: rtl/bin_cnt_down_timer.sv
// Programmable down-counting period timer: counts a latched period to zero and
// strobes tick on expiry, with one-shot/auto-reload, pause/resume and abort.
//
// state | meaning
// IDLE  | no run active, q held at 0, waiting for start
// RUN   | q decrements each cycle; q == 0 is the expiry (tick) cycle
// PAUSE | count frozen, start resumes without reload
module bin_cnt_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             busy,
  output logic             paused
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] period_reg, period_nxt;
  logic             mode_reg, mode_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      q          <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      period_reg <= period_nxt;
      mode_reg   <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    period_nxt = period_reg;
    mode_nxt   = mode_reg;
    if (abort) begin
      state_nxt = IDLE;
      q_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt  = RUN;
            period_nxt = load_val;
            mode_nxt   = mode;
            q_nxt      = load_val - 1'b1;
          end
        end
        RUN: begin
          // Expiry outranks pause: a one-shot always completes to IDLE.
          if (q == '0) begin
            if (mode_reg) begin
              q_nxt     = period_reg - 1'b1;
              state_nxt = pause ? PAUSE : RUN;
            end else begin
              state_nxt = IDLE;
            end
          end else if (pause) begin
            state_nxt = PAUSE;
          end else begin
            q_nxt = q - 1'b1;
          end
        end
        PAUSE: begin
          if (!pause && start) state_nxt = RUN;
        end
        default: begin
          state_nxt = IDLE;
          q_nxt     = '0;
        end
      endcase
    end
  end

  assign tick   = (state == RUN) && (q == '0);
  assign busy   = (state != IDLE);
  assign paused = (state == PAUSE);

endmodule

// File: tb/tb_bin_cnt_down_timer.sv
// Directed plus randomized checks of bin_cnt_down_timer against an integer
// cycle-count model of the timer behaviour.
module tb_bin_cnt_down_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] load_val;
  logic             mode, start, pause, abort;
  logic [WIDTH-1:0] q;
  logic             tick, busy, paused;

  int total = 0;
  int bad   = 0;

  // model: phase 0 = idle, 1 = counting, 2 = frozen; rem = cycles left before expiry
  int m_phase = 0;
  int m_rem   = 0;
  int m_len   = 0;
  bit m_auto  = 1'b0;

  bin_cnt_down_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load_val(load_val), .mode(mode),
    .start(start), .pause(pause), .abort(abort),
    .q(q), .tick(tick), .busy(busy), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rem   = 0;
    m_len   = 0;
    m_auto  = 1'b0;
  endtask

  task automatic model_edge();
    if (abort) begin
      m_phase = 0;
      m_rem   = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_len   = (load_val == 0) ? 256 : int'(load_val);
        m_auto  = mode;
        m_rem   = m_len - 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_rem == 0) begin
        if (m_auto) begin
          m_rem   = m_len - 1;
          m_phase = pause ? 2 : 1;
        end else begin
          m_phase = 0;
        end
      end else if (pause) begin
        m_phase = 2;
      end else begin
        m_rem = m_rem - 1;
      end
    end else begin
      if (!pause && start) m_phase = 1;
    end
  endtask

  task automatic chk_model();
    chk("model_q", q, m_rem);
    chk("model_tick", tick, (m_phase == 1 && m_rem == 0) ? 1 : 0);
    chk("model_busy", busy, (m_phase != 0) ? 1 : 0);
    chk("model_paused", paused, (m_phase == 2) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  task automatic idle_inputs();
    start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  int ticks;
  int first_tick;

  initial begin
    reset = 1'b0; load_val = '0; mode = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("reset_q", q, 0);
    chk("reset_tick", tick, 0);
    chk("reset_busy", busy, 0);
    chk("reset_paused", paused, 0);
    #1 reset = 1'b1;

    // one-shot, L = 5
    load_val = 8'd5; mode = 1'b0; start = 1'b1;
    step();
    chk("os_q_first", q, 4);
    chk("os_busy", busy, 1);
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("os_q", q, i);
      chk("os_tick", tick, (i == 0) ? 1 : 0);
    end
    step();
    chk("os_done_busy", busy, 0);
    chk("os_done_q", q, 0);

    // auto-reload, L = 3, 12 cycles
    load_val = 8'd3; mode = 1'b1; start = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      start = 1'b0;
      chk("ar_q", q, 2 - (i % 3));
      if (tick) ticks++;
    end
    chk("ar_ticks", ticks, 4);
    abort = 1'b1; step(); abort = 1'b0;

    // L = 0 means 256-cycle period
    load_val = 8'd0; mode = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk("l0_q_first", q, 255);
    first_tick = 0;
    for (int i = 2; i <= 300 && first_tick == 0; i++) begin
      step();
      if (tick) first_tick = i;
    end
    chk("l0_first_tick", first_tick, 256);
    abort = 1'b1; step(); abort = 1'b0;

    // L = 1 auto-reload: tick every cycle
    load_val = 8'd1; mode = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("l1_tick", tick, 1);
      step();
    end
    abort = 1'b1; step(); abort = 1'b0;

    // pause / resume, L = 6 auto-reload
    load_val = 8'd6; mode = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    chk("pr_q_before", q, 3);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pause = 1'b0;
      chk("pr_hold_q", q, 3);
      chk("pr_hold_tick", tick, 0);
      chk("pr_hold_paused", paused, 1);
    end
    start = 1'b1; step(); start = 1'b0;
    chk("pr_resume_q", q, 3);
    for (int i = 2; i >= 0; i--) begin
      step();
      chk("pr_run_q", q, i);
    end
    chk("pr_tick", tick, 1);
    pause = 1'b1; step(); pause = 1'b0;
    chk("pr_exp_paused", paused, 1);
    chk("pr_exp_q", q, 5);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("ab_q_before", q, 2);
    abort = 1'b1; step(); abort = 1'b0;
    chk("ab_q", q, 0);
    chk("ab_busy", busy, 0);

    // all commands together in RUN
    load_val = 8'd4; mode = 1'b1; start = 1'b1;
    step();
    abort = 1'b1; pause = 1'b1; step(); idle_inputs();
    chk("prio_busy", busy, 0);

    // start while running does not reload
    load_val = 8'd7; mode = 1'b0; start = 1'b1;
    step();
    load_val = 8'd2; step(); start = 1'b0;
    chk("norestart_q", q, 5);

    // asynchronous reset between edges
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("areset_q", q, 0);
    chk("areset_busy", busy, 0);
    chk("areset_tick", tick, 0);
    chk("areset_paused", paused, 0);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_busy", busy, 0);
    end

    // randomized commands
    for (int i = 0; i < 2000; i++) begin
      abort    = ($urandom_range(0, 31) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      start    = ($urandom_range(0, 3) == 0);
      mode     = $urandom_range(0, 1);
      load_val = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      step();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
